// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way round-robin arbiter.
//   ARB_N / ARB_ID_W : requester count and grant index width
//   arb_state_t      : arbiter FSM states
//   rotate_right     : circular right rotation used by the priority picker
package arb_pkg;

  localparam int ARB_N    = 16;
  localparam int ARB_ID_W = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  // Bit i of the result is bit (i + s) mod ARB_N of v, so the requester at
  // index s lands in position 0 and gets top priority in a lowest-index search.
  function automatic logic [ARB_N-1:0] rotate_right(input logic [ARB_N-1:0]    v,
                                                    input logic [ARB_ID_W-1:0] s);
    return (v >> s) | (v << (ARB_N - int'(s)));
  endfunction

endpackage

// File: rtl/rr_pick_16.sv
// Combinational round-robin picker for 16 requesters.
//   req     : request vector, bit i is requester i
//   last_id : most recently served requester; search starts just above it
//   enable  : gates any_req so no arbitration happens while disabled
//   winner  : first requester found searching upward from last_id+1 with wrap
//   any_req : enable is high and at least one request is present
module rr_pick_16
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_ID_W-1:0] last_id,
  input  logic                enable,
  output logic [ARB_ID_W-1:0] winner,
  output logic                any_req
);

  logic [ARB_ID_W-1:0] offset;
  logic [ARB_N-1:0]    rotated;
  logic [ARB_ID_W-1:0] pos;

  // The 4-bit add wraps naturally, giving (last_id + 1) mod 16.
  assign offset  = last_id + ARB_ID_W'(1);
  assign rotated = rotate_right(req, offset);

  // Fixed lowest-index priority on the rotated vector; scanning downward
  // lets the lowest set bit overwrite any higher one.
  always_comb begin
    pos = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rotated[i]) pos = ARB_ID_W'(i);
    end
  end

  // Undo the rotation; again the 4-bit add performs the mod 16.
  assign winner  = pos + offset;
  assign any_req = enable & (|req);

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter sharing one resource among 16 requesters.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   enable    : when low, no new grant is started
//   req       : level-sensitive request vector
//   gnt       : registered one-hot grant
//   gnt_id    : index of the granted requester, valid with gnt_valid
//   gnt_valid : a grant is active
//   preempt   : one-cycle pulse when a grant is cut off by MAX_HOLD
// A grant is held while its request stays high, up to MAX_HOLD cycles
// (0 = unlimited). Every grant is followed by at least one idle cycle.
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int ID_W     = ARB_ID_W,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            preempt
);

  // With MAX_HOLD = 0 the counter is unused; keep it one bit wide so the
  // declaration stays legal.
  localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_t      state, state_nx;
  logic [N-1:0]    gnt_nx;
  logic [ID_W-1:0] gnt_id_nx;
  logic            gnt_valid_nx;
  logic            preempt_nx;
  logic [ID_W-1:0] last_id, last_id_nx;
  logic [HC_W-1:0] hold_cnt, hold_cnt_nx;

  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            hold_limit;

  rr_pick_16 u_pick (
    .req     (req),
    .last_id (last_id),
    .enable  (enable),
    .winner  (winner),
    .any_req (any_req)
  );

  // hold_cnt counts cycles already held beyond the first, so reaching
  // MAX_HOLD-1 means the grant has been visible for MAX_HOLD cycles.
  assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      last_id   <= ID_W'(N - 1);
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      gnt_id    <= gnt_id_nx;
      gnt_valid <= gnt_valid_nx;
      preempt   <= preempt_nx;
      last_id   <= last_id_nx;
      hold_cnt  <= hold_cnt_nx;
    end
  end

  // Arbitration only happens from IDLE, so leaving BUSY always passes
  // through IDLE and produces the mandatory bubble. A dropped request takes
  // priority over the hold limit, so a release never pulses preempt.
  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    gnt_id_nx    = gnt_id;
    gnt_valid_nx = gnt_valid;
    preempt_nx   = 1'b0;
    last_id_nx   = last_id;
    hold_cnt_nx  = hold_cnt;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx         = BUSY;
          gnt_nx           = '0;
          gnt_nx[winner]   = 1'b1;
          gnt_id_nx        = winner;
          gnt_valid_nx     = 1'b1;
          hold_cnt_nx      = '0;
        end
      end
      BUSY: begin
        if (!req[gnt_id] || hold_limit) begin
          state_nx     = IDLE;
          gnt_nx       = '0;
          gnt_valid_nx = 1'b0;
          last_id_nx   = gnt_id;
          preempt_nx   = req[gnt_id];
        end else if (hold_cnt != '1) begin
          hold_cnt_nx = hold_cnt + HC_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
Round-robin arbiter that shares one downstream resource among 16 requesters, for example an encoder or datapath port. Each cycle it uses a masked priority search to choose the next requester. It holds that grant until the requester releases it or a hold limit expires, then rotates priority. It sits between the request lines and the resource's select/enable inputs.

Parameters:
N, 16, number of requesters; the design is verified at 16 only.
ID_W, 4, grant index width; equals clog2(N).
MAX_HOLD, 8, maximum grant length in cycles; 0 means unlimited.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  arbitration enable; when low, no new grant is issued
req  input  N  request vector; bit i is requester i, level-sensitive
gnt  output  N  one-hot grant, registered
gnt_id  output  ID_W  index of the granted requester; valid when gnt_valid=1
gnt_valid  output  1  a grant is active
preempt  output  1  one-cycle pulse when a grant is ended by MAX_HOLD

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE, last_id=N-1. After reset, requester 0 has highest priority.
- States: IDLE and BUSY. All outputs are registered.
- Arbitration happens only in IDLE.
  - If enable=1 and req!=0, the search starts at index (last_id+1) mod N, moves upward and wraps.
  - The first set bit wins.
  - On the next edge: state=BUSY, gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0.
- Latency: a request sampled at edge k produces a grant that is visible from edge k onward. This is one cycle from a request asserted before edge k.
- BUSY, normal hold: while req[gnt_id]=1, the grant is held and hold_cnt increments each cycle.
- BUSY, release: if req[gnt_id]=0 at an edge, the next edge sets gnt=0, gnt_valid=0, last_id=gnt_id and state=IDLE.
- BUSY, preempt: if MAX_HOLD!=0 and hold_cnt=MAX_HOLD-1 with req[gnt_id] still 1, the grant is forced off.
  - The grant therefore lasts exactly MAX_HOLD cycles.
  - Same edge as a release, plus preempt=1 for one cycle.
  - last_id=gnt_id, so the preempted requester moves to the back of the rotation.
- Mandatory bubble: gnt_valid is low for at least one cycle between any two grants, including a re-grant to the same requester. Minimum grant spacing is therefore grant length + 1.
- enable=0 in IDLE: no grant is issued and last_id is unchanged.
- enable=0 in BUSY: the current grant runs to its normal release or preempt; no new grant follows.
- Requests arriving or dropping on non-granted bits during BUSY have no effect until the next IDLE.
- Release and preempt on the same edge: preempt is only asserted if req[gnt_id] is still 1. A release therefore never pulses preempt.
- Reset mid-grant: all outputs clear immediately (asynchronously). Rotation restarts from requester 0.
- hold_cnt width: clog2(MAX_HOLD+1). It saturates and never wraps; the counter is unused when MAX_HOLD=0.
- The grant is always one-hot or zero. gnt_id always matches the set bit of gnt while gnt_valid=1.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - ARB_N=16 and ARB_ID_W=4;
  - the rotate-left/right helper function.
- One natural sub-module: rr_pick_16. It is combinational and takes req, last_id and enable. It outputs winner and any_req.
  - Implementation: rotate req by last_id+1, apply a fixed lowest-index priority search, then add the offset back mod N.
- The FSM, hold counter and output registers stay in rr_arbiter_16.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation with req=16'hFFFF → gnt=0, gnt_valid=0, preempt=0 immediately. After release, with req=16'h0001, first grant is gnt_id=0.
2. Rotation: req=16'h8011 held constant, MAX_HOLD=0, each requester drops its req after 2 granted cycles and re-raises it one cycle later → grant order 0, 4, 15, 0, 4. One gnt_valid=0 bubble between each grant.
3. Preempt: MAX_HOLD=4, req=16'h0008 held high → gnt_id=3 for exactly 4 cycles with preempt=1 on the drop edge, then 1 idle cycle, then re-grant to 3. With req=16'h0108 instead → 3, then 8, then 3.
4. Enable: enable=0 with req=16'h00F0 → no grant for 10 cycles. Drop enable in the 2nd cycle of a grant to 5 → grant completes at release and no further grant follows.
5. Ignore non-granted bits: while 2 is granted, toggle req[1] and req[9] every cycle → gnt unchanged. On release, the next winner is the first set bit from index 3 upward.
6. Same-edge release: MAX_HOLD=4, requester drops its req on cycle 4 → grant ends and preempt stays 0.
